// File: rtl/coin_sequencer.sv
// Coin pulse scheduler for the vending FSM. Coins are queued in a FIFO and
// replayed one at a time on r50/r100/r200, spaced by GAP_CYCLES low cycles.
module coin_sequencer #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       c50,
  input  logic                       c100,
  input  logic                       c200,
  input  logic [1:0]                 fsm_state,
  output logic                       r50,
  output logic                       r100,
  output logic                       r200,
  output logic [2:0]                 rej,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int GW = $clog2(GAP_CYCLES+1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t        state, state_nxt;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [GW-1:0] gap, gap_nxt;
  logic [1:0]    cur;
  logic          pop, gap_done;
  logic [1:0]    npush;
  logic [1:0]    wcode [3];
  logic [AW-1:0] waddr [3];
  logic [2:0]    rej_nxt, coins;

  assign coins    = {c200, c100, c50};
  assign gap_done = (state == GAP) && (gap == GW'(1));
  // The final gap cycle doubles as the idle decision so the spacing is exactly GAP_CYCLES.
  assign pop = (count != '0) && (fsm_state != 2'b11) && ((state == IDLE) || gap_done);

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap;
    case (state)
      IDLE:  if (pop) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = GAP;
        gap_nxt   = GW'(GAP_CYCLES);
      end
      GAP: begin
        if (gap_done) state_nxt = pop ? ISSUE : IDLE;
        else          gap_nxt   = gap - GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Largest coin claims a free slot first; free space already counts this cycle's pop.
  always_comb begin
    int free, n;
    free    = DEPTH - int'(count) + int'(pop);
    n       = 0;
    rej_nxt = '0;
    for (int j = 0; j < 3; j++) begin
      wcode[j] = '0;
      waddr[j] = wr_ptr + AW'(j);
    end
    for (int i = 2; i >= 0; i--) begin
      if (coins[i]) begin
        if (n < free) begin
          wcode[n] = 2'(i + 1);
          n++;
        end else begin
          rej_nxt[i] = 1'b1;
        end
      end
    end
    npush = 2'(n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gap    <= '0;
      cur    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rej    <= '0;
    end else begin
      state  <= state_nxt;
      gap    <= gap_nxt;
      rej    <= rej_nxt;
      if (pop) begin
        cur    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      wr_ptr <= wr_ptr + AW'(npush);
      count  <= count - CW'(pop) + CW'(npush);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 3; j++)
        if (j < int'(npush)) mem[waddr[j]] <= wcode[j];
    end
  end

  assign r50  = (state == ISSUE) && (cur == 2'b01);
  assign r100 = (state == ISSUE) && (cur == 2'b10);
  assign r200 = (state == ISSUE) && (cur == 2'b11);
  assign busy = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_coin_sequencer.sv
// Bench for coin_sequencer: directed vector table plus random traffic,
// both checked every cycle against a queue-based reference model.
module tb_coin_sequencer;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       rst, c50, c100, c200;
  logic [1:0] fsm_state;
  logic       r50, r100, r200, busy;
  logic [2:0] rej;
  logic [2:0] count;

  coin_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .c50(c50), .c100(c100), .c200(c200),
    .fsm_state(fsm_state), .r50(r50), .r100(r100), .r200(r200),
    .rej(rej), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] coin;   // {c200,c100,c50}
    logic [1:0] fs;
    logic [2:0] r;      // {r200,r100,r50}
    logic [2:0] rej;
    logic [2:0] cnt;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  int   q[$];
  int   last_pop, t, tests, fails;
  logic [2:0] m_r, m_rej;
  logic [2:0] m_cnt;
  logic       m_busy;

  function automatic vec_t mk(logic r_, logic [2:0] cn, logic [1:0] fs,
                              logic [2:0] er, logic [2:0] erj, logic [2:0] ec, logic eb);
    vec_t v;
    v.rst = r_; v.coin = cn; v.fs = fs; v.r = er; v.rej = erj; v.cnt = ec; v.busy = eb;
    return v;
  endfunction

  // Reference: a pop may happen at an edge when the queue is non-empty, the FSM
  // is not in DELAY and at least GAP+1 edges have passed since the last pop.
  task automatic model_edge(input logic r_, input logic [2:0] cn, input logic [1:0] fs);
    int code;
    t++;
    m_r = '0; m_rej = '0;
    if (r_) begin
      q.delete();
      last_pop = t - 100;
    end else begin
      if (q.size() != 0 && fs != 2'b11 && (t - last_pop) >= GAP + 1) begin
        code = q.pop_front();
        m_r[code-1] = 1'b1;
        last_pop = t;
      end
      for (int i = 2; i >= 0; i--)
        if (cn[i]) begin
          if (q.size() < DEPTH) q.push_back(i + 1);
          else m_rej[i] = 1'b1;
        end
    end
    m_cnt  = 3'(q.size());
    m_busy = (q.size() != 0) || ((t - last_pop) <= GAP);
  endtask

  task automatic chk(input string nm, input logic [2:0] er, input logic [2:0] erj,
                     input logic [2:0] ec, input logic eb);
    tests++;
    if ({r200, r100, r50} !== er || rej !== erj || count !== ec || busy !== eb) begin
      fails++;
      $display("FAIL %s t=%0d: got r=%b rej=%b count=%0d busy=%b, expected r=%b rej=%b count=%0d busy=%b",
               nm, t, {r200, r100, r50}, rej, count, busy, er, erj, ec, eb);
    end
  endtask

  task automatic apply(input logic r_, input logic [2:0] cn, input logic [1:0] fs);
    rst = r_; {c200, c100, c50} = cn; fsm_state = fs;
    @(posedge clk);
    model_edge(r_, cn, fs);
    #1;
    chk("model", m_r, m_rej, m_cnt, m_busy);
  endtask

  initial begin
    logic [1:0] fs_cur;
    logic [2:0] cn;
    logic       r_;
    tests = 0; fails = 0; t = 0; last_pop = -100;
    rst = 1'b1; c50 = 1'b0; c100 = 1'b0; c200 = 1'b0; fsm_state = 2'b00;

    // reset with c50 pulsing, then single coin
    tbl.push_back(mk(1, 3'b001, 0, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mk(1, 3'b001, 0, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0, 3'b000, 3'b000, 1, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b010, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
    // three coins in one cycle: 200, 100, 50 with two low cycles between
    tbl.push_back(mk(0, 3'b111, 0, 3'b000, 3'b000, 3, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b100, 3'b000, 2, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 2, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 2, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b010, 3'b000, 1, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 1, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 1, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b001, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
    // overflow while the FSM sits in DELAY, then drain
    tbl.push_back(mk(0, 3'b100, 3, 3'b000, 3'b000, 1, 1));
    tbl.push_back(mk(0, 3'b100, 3, 3'b000, 3'b000, 2, 1));
    tbl.push_back(mk(0, 3'b111, 3, 3'b000, 3'b001, 4, 1));
    tbl.push_back(mk(0, 3'b000, 3, 3'b000, 3'b000, 4, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b100, 3'b000, 3, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 3, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 3, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b100, 3'b000, 2, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 2, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 2, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b100, 3'b000, 1, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 1, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 1, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b010, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 0));
    // full FIFO popping accepts a coin on the same edge; then reset mid-pulse
    tbl.push_back(mk(0, 3'b111, 3, 3'b000, 3'b000, 3, 1));
    tbl.push_back(mk(0, 3'b100, 3, 3'b000, 3'b000, 4, 1));
    tbl.push_back(mk(0, 3'b001, 0, 3'b100, 3'b000, 4, 1));
    tbl.push_back(mk(1, 3'b000, 0, 3'b000, 3'b000, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 3'b000, 3'b000, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].rst, tbl[k].coin, tbl[k].fs);
      chk($sformatf("vec%0d", k), tbl[k].r, tbl[k].rej, tbl[k].cnt, tbl[k].busy);
    end

    // coin queued during DELAY is held until the FSM leaves DELAY
    apply(0, 3'b010, 3);
    for (int k = 0; k < 6; k++) begin
      apply(0, 3'b000, 3);
      chk("delay_hold", 3'b000, 3'b000, 1, 1);
    end
    apply(0, 3'b000, 0);
    chk("delay_release", 3'b010, 3'b000, 0, 1);

    // random traffic against the model
    fs_cur = 2'b00;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) fs_cur = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      cn[0] = ($urandom_range(0, 3) == 0);
      cn[1] = ($urandom_range(0, 3) == 0);
      cn[2] = ($urandom_range(0, 3) == 0);
      r_    = ($urandom_range(0, 299) == 0);
      apply(r_, cn, fs_cur);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
